// File: rtl/mem_access_stage_if.sv
`timescale 1ns/1ps
// Data-memory port bundle for mem_access_stage: req/ack handshake plus
// address, byte enables and data in both directions.
interface mem_access_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [3:0]            dmem_be;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_ack;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
// Memory-access pipeline stage: req/ack data-memory transaction, store lane
// steering, load extraction/extension. Define MEM_TIMEOUT_EN for the WAIT watchdog.
module mem_access_stage #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  mem_enable_in,
  input  logic                  mem_rw_in,
  input  logic [1:0]            mem_width_in,
  input  logic                  sign_extend_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] write_data_in,
  mem_access_stage_if.master    dmem,
  output logic                  stall_req,
  output logic [DATA_WIDTH-1:0] load_data_out,
  output logic                  load_valid_out,
  output logic                  addr_error_out,
  output logic                  bus_error_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t                state;

  // Bus-facing registers; zero outside WAIT
  logic                  req_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] baddr_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Holding registers for load extraction and flush tracking
  logic [1:0]            addr_lo_q;
  logic [1:0]            width_q;
  logic                  sext_q;
  logic                  kill_q;

  logic                  legal;
  logic                  start;
  logic [3:0]            be_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_ext;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             bus_err_q;

  assign wait_cnt_next = wait_cnt + 1'b1;
  assign bus_error_out = bus_err_q;
`else
  assign bus_error_out = 1'b0;
`endif

  // Alignment check and store lane steering from the incoming instruction
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    legal      = 1'b0;
    be_next    = 4'b0000;
    wdata_next = write_data_in;
    case (mem_width_in)
      2'd0: begin
        legal      = 1'b1;
        be_next    = 4'b0001 << addr_in[1:0];
        wdata_next = {4{write_data_in[7:0]}};
      end
      2'd1: begin
        legal      = ~addr_in[0];
        be_next    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{write_data_in[15:0]}};
      end
      2'd2: begin
        legal      = (addr_in[1:0] == 2'b00);
        be_next    = 4'b1111;
      end
      default: ;
    endcase
  end

  assign start     = mem_enable_in & ~flush & legal;
  assign stall_req = ((state == ST_IDLE) & start) | (state == ST_WAIT);

  // Lane extraction and extension of the returned word, driven by the held access
  always_comb begin
    load_byte = dmem.dmem_rdata[{addr_lo_q, 3'b000} +: 8];
    load_half = dmem.dmem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
    case (width_q)
      2'd0:    load_ext = {{24{sext_q & load_byte[7]}}, load_byte};
      2'd1:    load_ext = {{16{sext_q & load_half[15]}}, load_half};
      default: load_ext = dmem.dmem_rdata;
    endcase
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = baddr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; all state here uses non-blocking assignments only.
    if (!rst_n) begin
      state          <= ST_IDLE;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      baddr_q        <= '0;
      be_q           <= 4'b0000;
      wdata_q        <= '0;
      addr_lo_q      <= 2'b00;
      width_q        <= 2'b00;
      sext_q         <= 1'b0;
      kill_q         <= 1'b0;
      load_data_out  <= '0;
      load_valid_out <= 1'b0;
      addr_error_out <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt       <= '0;
      bus_err_q      <= 1'b0;
`endif
    end else begin
      load_valid_out <= 1'b0;
      addr_error_out <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err_q      <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_WAIT;
            req_q     <= 1'b1;
            we_q      <= mem_rw_in;
            baddr_q   <= {addr_in[ADDR_WIDTH-1:2], 2'b00};
            be_q      <= be_next;
            wdata_q   <= wdata_next;
            addr_lo_q <= addr_in[1:0];
            width_q   <= mem_width_in;
            sext_q    <= sign_extend_in;
`ifdef MEM_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end else if (mem_enable_in && !flush) begin
            addr_error_out <= 1'b1;
          end
        end

        ST_WAIT: begin
          // The bus cycle is never aborted; a flush only suppresses the load result
          if (flush) kill_q <= 1'b1;
          if (dmem.dmem_ack) begin
            state   <= ST_DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            baddr_q <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            if (!we_q && !kill_q && !flush) begin
              load_data_out  <= load_ext;
              load_valid_out <= 1'b1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (wait_cnt_next == CNT_W'(TIMEOUT_CYCLES)) begin
            state     <= ST_DONE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            baddr_q   <= '0;
            be_q      <= 4'b0000;
            wdata_q   <= '0;
            bus_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt_next;
          end
`endif
        end

        ST_DONE: begin
          // Inputs still show the finished instruction here; it must not restart
          state  <= ST_IDLE;
          kill_q <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
// Self-checking bench for mem_access_stage: directed plan cases plus randomized
// accesses scored against an arithmetic reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        mem_enable_in;
  logic        mem_rw_in;
  logic [1:0]  mem_width_in;
  logic        sign_extend_in;
  logic [31:0] addr_in;
  logic [31:0] write_data_in;
  logic        stall_req;
  logic [31:0] load_data_out;
  logic        load_valid_out;
  logic        addr_error_out;
  logic        bus_error_out;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_load_data;

  mem_access_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dmem_if ();

  mem_access_stage #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .mem_enable_in (mem_enable_in),
    .mem_rw_in     (mem_rw_in),
    .mem_width_in  (mem_width_in),
    .sign_extend_in(sign_extend_in),
    .addr_in       (addr_in),
    .write_data_in (write_data_in),
    .dmem          (dmem_if.master),
    .stall_req     (stall_req),
    .load_data_out (load_data_out),
    .load_valid_out(load_valid_out),
    .addr_error_out(addr_error_out),
    .bus_error_out (bus_error_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Reference model: lane rules expressed as shifts, masks and multiplies
  function automatic logic [3:0] ref_be(input logic [1:0] w, input logic [31:0] a);
    int off = int'(a[1:0]);
    case (w)
      2'd0:    return 4'((1 << off) & 15);
      2'd1:    return 4'((3 << off) & 15);
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] w, input logic [31:0] d);
    case (w)
      2'd0:    return (d & 32'hFF) * 32'h0101_0101;
      2'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] w, input logic s,
                                           input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    int off = int'(a[1:0]);
    case (w)
      2'd0: begin
        v = (r >> (8 * off)) & 32'hFF;
        if (s && v >= 32'd128) v = v - 32'd256;
      end
      2'd1: begin
        v = (r >> (8 * off)) & 32'hFFFF;
        if (s && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = r;
    endcase
    return v;
  endfunction

  function automatic logic ref_legal(input logic [1:0] w, input logic [31:0] a);
    return (w == 2'd0) || (w == 2'd1 && a % 2 == 0) || (w == 2'd2 && a % 4 == 0);
  endfunction

  // One instruction presented to the stage; flush_at = WAIT cycle (1-based) carrying flush, 0 = none
  task automatic run_op(input logic rw, input logic [1:0] w, input logic s,
                        input logic [31:0] a, input logic [31:0] d, input int waits,
                        input logic [31:0] rdata, input int flush_at, input string tag);
    logic legal;
    logic exp_valid;
    legal = ref_legal(w, a);
    @(negedge clk);
    mem_enable_in = 1'b1; mem_rw_in = rw; mem_width_in = w; sign_extend_in = s;
    addr_in = a; write_data_in = d; flush = 1'b0; dmem_if.dmem_ack = 1'b0;
    #1;
    n_tests++;
    if (stall_req !== legal) begin
      n_fail++; $display("FAIL %s idle_stall: got %b expected %b", tag, stall_req, legal);
    end
    @(posedge clk); @(negedge clk);
    if (!legal) begin
      n_tests++;
      if (addr_error_out !== 1'b1 || dmem_if.dmem_req !== 1'b0 || stall_req !== 1'b0) begin
        n_fail++; $display("FAIL %s addr_err: got err=%b req=%b stall=%b expected 1 0 0",
                           tag, addr_error_out, dmem_if.dmem_req, stall_req);
      end
      mem_enable_in = 1'b0;
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (addr_error_out !== 1'b0) begin
        n_fail++; $display("FAIL %s addr_err_pulse: got %b expected 0", tag, addr_error_out);
      end
      return;
    end
    for (int i = 1; i <= waits; i++) begin
      n_tests++;
      if (dmem_if.dmem_req !== 1'b1 || stall_req !== 1'b1 || dmem_if.dmem_we !== rw ||
          dmem_if.dmem_addr !== (a & 32'hFFFF_FFFC) || dmem_if.dmem_be !== ref_be(w, a)) begin
        n_fail++; $display("FAIL %s wait%0d_bus: got req=%b stall=%b we=%b addr=%h be=%b expected 1 1 %b %h %b",
                           tag, i, dmem_if.dmem_req, stall_req, dmem_if.dmem_we, dmem_if.dmem_addr,
                           dmem_if.dmem_be, rw, a & 32'hFFFF_FFFC, ref_be(w, a));
      end
      if (rw) begin
        n_tests++;
        if (dmem_if.dmem_wdata !== ref_wdata(w, d)) begin
          n_fail++; $display("FAIL %s wait%0d_wdata: got %h expected %h", tag, i,
                             dmem_if.dmem_wdata, ref_wdata(w, d));
        end
      end
      flush = (i == flush_at);
      if (i == waits) begin
        dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = rdata;
      end
      @(posedge clk); @(negedge clk);
    end
    dmem_if.dmem_ack = 1'b0; flush = 1'b0; dmem_if.dmem_rdata = $urandom;
    exp_valid = !rw && (flush_at == 0);
    if (exp_valid) exp_load_data = ref_load(w, s, a, rdata);
    #1;
    n_tests++;
    if (load_valid_out !== exp_valid || load_data_out !== exp_load_data) begin
      n_fail++; $display("FAIL %s done_load: got valid=%b data=%h expected %b %h", tag,
                         load_valid_out, load_data_out, exp_valid, exp_load_data);
    end
    n_tests++;
    if (dmem_if.dmem_req !== 1'b0 || stall_req !== 1'b0 || dmem_if.dmem_be !== 4'b0000 ||
        bus_error_out !== 1'b0) begin
      n_fail++; $display("FAIL %s done_idle: got req=%b stall=%b be=%b berr=%b expected 0 0 0000 0",
                         tag, dmem_if.dmem_req, stall_req, dmem_if.dmem_be, bus_error_out);
    end
    @(posedge clk); @(negedge clk);
    mem_enable_in = 1'b0;
    #1;
    n_tests++;
    if (load_valid_out !== 1'b0 || dmem_if.dmem_req !== 1'b0 || load_data_out !== exp_load_data) begin
      n_fail++; $display("FAIL %s after_done: got valid=%b req=%b data=%h expected 0 0 %h", tag,
                         load_valid_out, dmem_if.dmem_req, load_data_out, exp_load_data);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_tests++;
    if ({dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_be, dmem_if.dmem_wdata} !== '0 ||
        {stall_req, load_valid_out, addr_error_out, bus_error_out} !== 4'b0000 ||
        load_data_out !== 32'h0) begin
      n_fail++; $display("FAIL %s outputs: got req=%b stall=%b valid=%b err=%b berr=%b data=%h be=%b expected all 0",
                         tag, dmem_if.dmem_req, stall_req, load_valid_out, addr_error_out,
                         bus_error_out, load_data_out, dmem_if.dmem_be);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; mem_enable_in = 1'b0; mem_rw_in = 1'b0; mem_width_in = 2'd0;
    sign_extend_in = 1'b0; addr_in = '0; write_data_in = '0;
    dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    exp_load_data = 32'h0;
    rst_n = 1'b1;
  endtask

  task automatic test_word_load;
    run_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 2, 32'hDEAD_BEEF, 0, "word_load");
    n_tests++;
    if (load_data_out !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL word_load_value: got %h expected deadbeef", load_data_out);
    end
  endtask

  task automatic test_byte_load;
    run_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1, 32'h80FF_0000, 0, "sbyte_load");
    n_tests++;
    if (load_data_out !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL sbyte_value: got %h expected ffffff80", load_data_out);
    end
    run_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 3, 32'h80FF_0000, 0, "ubyte_load");
    n_tests++;
    if (load_data_out !== 32'h0000_0080) begin
      n_fail++; $display("FAIL ubyte_value: got %h expected 00000080", load_data_out);
    end
    run_op(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1, 32'h8001_7FFF, 0, "shalf_load");
  endtask

  task automatic test_half_store;
    run_op(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_ABCD, 2, 32'h5555_5555, 0, "half_store");
    run_op(1'b1, 2'd0, 1'b0, 32'h301, 32'hCAFE_F00D, 1, 32'h0, 0, "byte_store");
  endtask

  task automatic test_misaligned;
    run_op(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 1, 32'h0, 0, "word_misalign");
    run_op(1'b1, 2'd1, 1'b0, 32'h203, 32'h0, 1, 32'h0, 0, "half_misalign");
    run_op(1'b0, 2'd3, 1'b0, 32'h200, 32'h0, 1, 32'h0, 0, "width_illegal");
  endtask

  task automatic test_flush;
    run_op(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 2, 32'h1357_9BDF, 1, "flush_wait");
    // Follow-up load proves the kill bit was cleared on return to IDLE
    run_op(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 1, 32'h2468_ACE0, 0, "after_flush");
  endtask

  task automatic test_reset_in_wait;
    @(negedge clk);
    mem_enable_in = 1'b1; mem_rw_in = 1'b1; mem_width_in = 2'd2; addr_in = 32'h500;
    write_data_in = 32'hA5A5_A5A5; flush = 1'b0; dmem_if.dmem_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    n_tests++;
    if (dmem_if.dmem_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_wait_pre: got req=%b expected 1", dmem_if.dmem_req);
    end
    rst_n = 1'b0; mem_enable_in = 1'b0;
    @(posedge clk); @(negedge clk);
    exp_load_data = 32'h0;
    check_all_zero("rst_in_wait");
    rst_n = 1'b1; mem_rw_in = 1'b0;
    dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    dmem_if.dmem_ack = 1'b0;
    check_all_zero("late_ack");
  endtask

  task automatic test_random;
    for (int k = 0; k < 60; k++) begin
      logic [1:0]  w;
      logic [31:0] a;
      int          waits;
      int          fa;
      w     = 2'($urandom_range(0, 3));
      a     = $urandom;
      waits = int'($urandom_range(1, 4));
      fa    = (waits > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, waits - 1)) : 0;
      run_op(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), a, $urandom, waits,
             $urandom, fa, $sformatf("rand%0d", k));
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    @(negedge clk);
    mem_enable_in = 1'b1; mem_rw_in = 1'b0; mem_width_in = 2'd2; addr_in = 32'h600;
    flush = 1'b0; dmem_if.dmem_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      n_tests++;
      if (dmem_if.dmem_req !== 1'b1 || bus_error_out !== 1'b0) begin
        n_fail++; $display("FAIL timeout_wait%0d: got req=%b berr=%b expected 1 0", i,
                           dmem_if.dmem_req, bus_error_out);
      end
      @(posedge clk); @(negedge clk);
    end
    n_tests++;
    if (dmem_if.dmem_req !== 1'b0 || bus_error_out !== 1'b1 || load_valid_out !== 1'b0 ||
        stall_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_done: got req=%b berr=%b valid=%b stall=%b expected 0 1 0 0",
                         dmem_if.dmem_req, bus_error_out, load_valid_out, stall_req);
    end
    @(posedge clk); @(negedge clk);
    mem_enable_in = 1'b0;
    n_tests++;
    if (bus_error_out !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse: got berr=%b expected 0", bus_error_out);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_word_load;
    test_byte_load;
    test_half_store;
    test_misaligned;
    test_flush;
    test_reset_in_wait;
    test_random;
`ifdef MEM_TIMEOUT_EN
    test_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage. Sits between the exec-to-mem pipeline register and the mem-to-wb pipeline register.
- Consumes the registered exec outputs and runs a req/ack transaction on the data-memory port.
- Performs byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
- Holds the upstream pipeline through stall_req until the memory transaction finishes.

Parameters:
ADDR_WIDTH, 32, byte-address width
DATA_WIDTH, 32, data word width; fixed at 32 for lane logic
TIMEOUT_CYCLES, 255, WAIT-state watchdog limit; used only with MEM_TIMEOUT_EN

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; synchronous, active-low
flush  in  1  kill the current instruction's memory effect
mem_enable_in  in  1  instruction accesses memory
mem_rw_in  in  1  1=store, 0=load
mem_width_in  in  2  0=byte, 1=half, 2=word, 3=illegal
sign_extend_in  in  1  load sign-extend (1) / zero-extend (0)
addr_in  in  ADDR_WIDTH  effective byte address (ALU result)
write_data_in  in  DATA_WIDTH  store data, right-justified
dmem_req  out  1  memory request
dmem_we  out  1  write enable
dmem_addr  out  ADDR_WIDTH  word-aligned address, addr[1:0] forced to 0
dmem_be  out  4  byte enables
dmem_wdata  out  DATA_WIDTH  lane-replicated store data
dmem_ack  in  1  transaction complete; dmem_rdata valid
dmem_rdata  in  DATA_WIDTH  read word
stall_req  out  1  freeze upstream stages
load_data_out  out  DATA_WIDTH  extracted and extended load result
load_valid_out  out  1  load_data_out valid, one-cycle pulse
addr_error_out  out  1  misaligned or illegal access, one-cycle pulse
bus_error_out  out  1  watchdog timeout pulse; tied 0 without MEM_TIMEOUT_EN

Behaviour:
- FSM states: IDLE, WAIT, DONE.
- start = mem_enable_in & !flush & aligned & (mem_width_in != 3).
- aligned: byte always; half requires addr[0]=0; word requires addr[1:0]=0.
- IDLE
  - On start: latch addr, rw, width, sign_extend, lanes and data into holding registers; go to WAIT.
  - On mem_enable_in & !flush & !(aligned & width != 3): addr_error_out=1 next cycle for one cycle; no request; stay in IDLE.
  - Otherwise stay in IDLE.
- WAIT
  - dmem_req=1; dmem_we/addr/be/wdata driven from the holding registers, stable until ack.
  - On dmem_ack: go to DONE.
  - If the held access is a load and no kill is pending, capture the extracted rdata into load_data_out and set load_valid_out=1 (registered, visible during DONE).
- DONE
  - All outputs idle except load_data_out/load_valid_out.
  - Go to IDLE next cycle.
  - The instruction still present at the inputs in DONE is never reissued.
- stall_req (combinational) = (IDLE & start) | WAIT. It is 0 in DONE, so the upstream register advances at the end of DONE.
- Latency: a memory op takes at least 3 cycles (IDLE, WAIT, DONE); each extra WAIT cycle adds one. A non-memory op takes 0 stall cycles.
- Store lanes:
  - byte: be = 1 << addr[1:0]; wdata = {4{data[7:0]}}
  - half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}
  - word: be = 4'b1111; wdata = data
- Load extract:
  - byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16]
  - Extend to 32 bits by the latched sign_extend.
  - dmem_be for loads is the same lane pattern as for stores.
- Flush in WAIT: the bus transaction is not aborted. A kill bit is set; on ack, DONE is entered with load_valid_out=0. The kill bit clears on IDLE entry.
- load_valid_out and addr_error_out are single-cycle pulses. load_data_out holds its value until the next captured load.
- Reset values: state=IDLE; every output 0, including holding registers and load_data_out. Reset in WAIT drops dmem_req the next cycle; any late ack is ignored in IDLE.
- dmem_ack outside WAIT is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined: an 8+ bit counter clears on WAIT entry and increments each WAIT cycle without ack. When it reaches TIMEOUT_CYCLES:
  - dmem_req drops and the FSM goes to DONE with load_valid_out=0;
  - bus_error_out pulses for one cycle, in the DONE cycle.
- When undefined: no counter; WAIT lasts indefinitely until ack; bus_error_out is constant 0.

Test Plan:
- Word load, addr=0x100, ack after 2 WAIT cycles, rdata=0xDEADBEEF -> stall_req high 3 cycles, dmem_be=1111, load_data_out=0xDEADBEEF, load_valid_out pulse in DONE.
- Signed byte load, addr=0x103, rdata=0x80FF0000 -> be=1000, load_data_out=0xFFFFFF80. Same with sign_extend=0 -> 0x00000080.
- Half store, addr=0x202, data=0x1234ABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD, dmem_addr=0x200, no load_valid.
- Word load, addr=0x101 -> no dmem_req, stall_req=0, addr_error_out single pulse.
- Flush during WAIT of a load, ack next cycle -> transaction completes, load_valid_out stays 0, FSM returns to IDLE. Separately, rst_n=0 in WAIT -> dmem_req=0 next cycle, all outputs 0.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, never ack -> dmem_req drops after 4 WAIT cycles, bus_error_out pulse, stall_req released.
